// File: rtl/mipi_pack_pkg.sv
// Shared types and constants for the MIPI pixel packer.
// Optional crop window is enabled with the MIPI_PACK_CROP_EN macro.
package mipi_pack_pkg;

    typedef enum logic {
        WAIT_FRAME,
        IN_FRAME
    } state_t;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/mipi_pack_if.sv
// Avalon-ST source bus carrying packed pixel words with frame/line flags.
interface mipi_pack_if #(
    parameter int OUT_W = 32
);
    logic [OUT_W-1:0] data;
    logic             valid;
    logic             ready;
    logic             sof;
    logic             eol;

    modport master (output data, valid, sof, eol, input ready);
    modport slave  (input data, valid, sof, eol, output ready);
endinterface

// File: rtl/mipi_pack_fifo.sv
// Sync FIFO of {sof, eol, data} with a registered head word driving the stream.
// The head register counts toward DEPTH, so DEPTH words in total can be held.
module mipi_pack_fifo
    import mipi_pack_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_push,
    input  logic              i_sof,
    input  logic              i_eol,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_full,
    mipi_pack_if.master       o_av
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W+1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [DATA_W+1:0] r_out;
    logic              r_out_valid;

    logic [DATA_W+1:0] w_in;
    logic [CW-1:0]     w_total;
    logic              w_pop;
    logic              w_load;
    logic              w_mem_empty;
    logic              w_accept;
    logic              w_rd_mem;
    logic              w_wr_mem;

    assign w_in        = {i_sof, i_eol, i_data};
    assign w_pop       = r_out_valid & o_av.ready;
    assign w_load      = !r_out_valid | w_pop;
    assign w_mem_empty = (r_count == '0);
    assign w_total     = r_count + CW'(r_out_valid);
    assign o_full      = (w_total == CW'(DEPTH));
    assign w_accept    = i_push & (!o_full | w_pop);
    assign w_rd_mem    = w_load & !w_mem_empty;
    // An empty FIFO with a free head register bypasses storage entirely.
    assign w_wr_mem    = w_accept & !(w_load & w_mem_empty);

    always_ff @(posedge clk) begin
        if (w_wr_mem) begin
            r_mem[r_wr_ptr] <= w_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_wr_mem) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_mem) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_wr_mem) - CW'(w_rd_mem);
            if (w_load) begin
                if (w_rd_mem) begin
                    r_out       <= r_mem[r_rd_ptr];
                    r_out_valid <= 1'b1;
                end else if (w_accept) begin
                    r_out       <= w_in;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign o_av.data  = r_out[DATA_W-1:0];
    assign o_av.eol   = r_out[DATA_W];
    assign o_av.sof   = r_out[DATA_W+1];
    assign o_av.valid = r_out_valid;
endmodule

// File: rtl/mipi_pixel_packer.sv
// Packs MIPI bridge pixels into words and streams them out through a FIFO.
// Define MIPI_PACK_CROP_EN to add a crop window latched at frame start.
module mipi_pixel_packer
    import mipi_pack_pkg::*;
#(
    parameter int PIXEL_W      = 10,
    parameter int PIX_PER_WORD = 3,
    parameter int OUT_W        = 32,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
`ifdef MIPI_PACK_CROP_EN
    input  logic [15:0]        i_crop_x,
    input  logic [15:0]        i_crop_y,
    input  logic [15:0]        i_crop_w,
    input  logic [15:0]        i_crop_h,
`endif
    input  logic [PIXEL_W-1:0] i_pix_d,
    input  logic               i_pix_hs,
    input  logic               i_pix_vs,
    input  logic               i_capture_en,
    input  logic               i_ovf_clr,
    output logic [CNT_W-1:0]   o_frame_count,
    output logic               o_ovf_flag,
    output logic [CNT_W-1:0]   o_drop_count,
    mipi_pack_if.master        o_av
);
    localparam int PACK_W = PIXEL_W * PIX_PER_WORD;
    localparam int SW     = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

    if (OUT_W < PACK_W) begin : g_width_check
        $error("mipi_pixel_packer: OUT_W must be at least PIXEL_W*PIX_PER_WORD");
    end

    state_t            r_state, w_state_next;
    logic              r_vs_d, r_acc_d, r_sof_pend;
    logic [SW-1:0]     r_slot;
    logic [PACK_W-1:0] r_word, w_word_ins;
    logic              r_push_valid, r_push_eol;
    logic [PACK_W-1:0] r_push_data;
    logic              w_vs_rise, w_vs_fall, w_active, w_acc, w_line_end;
    logic              w_crop_ok, w_full, w_drop;

    assign w_vs_rise  = i_pix_vs & !r_vs_d;
    assign w_vs_fall  = !i_pix_vs & r_vs_d;
    assign w_active   = (r_state == IN_FRAME) & i_pix_hs & i_pix_vs;
    assign w_acc      = w_active & w_crop_ok;
    // The accepted run of a line ends on the first cycle without a pixel.
    assign w_line_end = r_acc_d & !w_acc;

`ifdef MIPI_PACK_CROP_EN
    logic [15:0] r_cx, r_cy, r_cw, r_ch, r_x, r_y;
    logic        r_hs_d, w_x_ok, w_y_ok;

    assign w_x_ok = (r_cw == '0) | (({1'b0, r_x} >= {1'b0, r_cx}) &&
                    ({1'b0, r_x} < ({1'b0, r_cx} + {1'b0, r_cw})));
    assign w_y_ok = (r_ch == '0) | (({1'b0, r_y} >= {1'b0, r_cy}) &&
                    ({1'b0, r_y} < ({1'b0, r_cy} + {1'b0, r_ch})));
    assign w_crop_ok = w_x_ok & w_y_ok;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            {r_cx, r_cy, r_cw, r_ch, r_x, r_y} <= '0;
            r_hs_d <= i_pix_hs;
        end else begin
            r_hs_d <= i_pix_hs;
            if (w_vs_rise) begin
                {r_cx, r_cy, r_cw, r_ch} <= {i_crop_x, i_crop_y, i_crop_w, i_crop_h};
                r_y <= '0;
            end else if (!i_pix_hs && r_hs_d && r_state == IN_FRAME) begin
                r_y <= r_y + 16'd1;
            end
            if (!i_pix_hs)     r_x <= '0;
            else if (w_active) r_x <= r_x + 16'd1;
        end
    end
`else
    assign w_crop_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        r_state <= !reset_n ? WAIT_FRAME : w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WAIT_FRAME: if (w_vs_rise && i_capture_en) w_state_next = IN_FRAME;
            IN_FRAME:   if (w_vs_fall) w_state_next = WAIT_FRAME;
            default:    w_state_next = WAIT_FRAME;
        endcase
    end

    always_comb begin
        w_word_ins = r_word;
        for (int i = 0; i < PIX_PER_WORD; i++) begin
            if (r_slot == SW'(i)) w_word_ins[i*PIXEL_W +: PIXEL_W] = i_pix_d;
        end
    end

    // Sampling vs during reset keeps a frame already in progress from looking like a new one.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_vs_d       <= i_pix_vs;
            r_acc_d      <= 1'b0;
            r_sof_pend   <= 1'b0;
            r_slot       <= '0;
            r_word       <= '0;
            r_push_valid <= 1'b0;
            r_push_eol   <= 1'b0;
            r_push_data  <= '0;
        end else begin
            r_vs_d       <= i_pix_vs;
            r_acc_d      <= w_acc;
            r_push_valid <= 1'b0;
            r_push_eol   <= 1'b0;
            if (w_vs_rise && i_capture_en && r_state == WAIT_FRAME) r_sof_pend <= 1'b1;
            else if (r_push_valid)                                 r_sof_pend <= 1'b0;
            if (w_acc) begin
                if (r_slot == SW'(PIX_PER_WORD - 1)) begin
                    r_push_valid <= 1'b1;
                    r_push_data  <= w_word_ins;
                    r_word       <= '0;
                    r_slot       <= '0;
                end else begin
                    r_word <= w_word_ins;
                    r_slot <= r_slot + SW'(1);
                end
            end else if (w_line_end && r_slot != '0) begin
                r_push_valid <= 1'b1;
                r_push_data  <= r_word;
                r_push_eol   <= 1'b1;
                r_word       <= '0;
                r_slot       <= '0;
            end
        end
    end

    assign w_drop = r_push_valid & w_full & !(o_av.valid & o_av.ready);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            o_frame_count <= '0;
            o_ovf_flag    <= 1'b0;
            o_drop_count  <= '0;
        end else begin
            if (w_vs_fall) o_frame_count <= o_frame_count + CNT_W'(1);
            if (i_ovf_clr) begin
                o_ovf_flag   <= 1'b0;
                o_drop_count <= '0;
            end else if (w_drop) begin
                o_ovf_flag   <= 1'b1;
                o_drop_count <= sat_inc(o_drop_count);
            end
        end
    end

    // A full word waiting in the push register is the line's last if the run ends now.
    mipi_pack_fifo #(
        .DATA_W (OUT_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (r_push_valid),
        .i_sof   (r_sof_pend),
        .i_eol   (r_push_eol | w_line_end),
        .i_data  (OUT_W'(r_push_data)),
        .o_full  (w_full),
        .o_av    (o_av)
    );
endmodule

// File: tb/tb_mipi_pixel_packer.sv
// Directed self-checking bench for mipi_pixel_packer (crop test under MIPI_PACK_CROP_EN).
module tb_mipi_pixel_packer;
    logic        clk;
    logic        reset_n;
    logic [9:0]  i_pix_d;
    logic        i_pix_hs, i_pix_vs, i_capture_en, i_ovf_clr;
    logic [15:0] o_frame_count, o_drop_count;
    logic        o_ovf_flag;
`ifdef MIPI_PACK_CROP_EN
    logic [15:0] i_crop_x, i_crop_y, i_crop_w, i_crop_h;
`endif

    int tests = 0;
    int fails = 0;
    logic [31:0] q_data[$];
    bit          q_sof[$];
    bit          q_eol[$];

    mipi_pack_if #(.OUT_W(32)) av ();

    mipi_pixel_packer dut (
        .clk           (clk),
        .reset_n       (reset_n),
`ifdef MIPI_PACK_CROP_EN
        .i_crop_x      (i_crop_x),
        .i_crop_y      (i_crop_y),
        .i_crop_w      (i_crop_w),
        .i_crop_h      (i_crop_h),
`endif
        .i_pix_d       (i_pix_d),
        .i_pix_hs      (i_pix_hs),
        .i_pix_vs      (i_pix_vs),
        .i_capture_en  (i_capture_en),
        .i_ovf_clr     (i_ovf_clr),
        .o_frame_count (o_frame_count),
        .o_ovf_flag    (o_ovf_flag),
        .o_drop_count  (o_drop_count),
        .o_av          (av)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (av.valid && av.ready) begin
            q_data.push_back(av.data);
            q_sof.push_back(av.sof);
            q_eol.push_back(av.eol);
        end
    end

    task automatic clear_q();
        q_data.delete();
        q_sof.delete();
        q_eol.delete();
    endtask

    task automatic cyc(input logic hs, input logic vs, input int d);
        i_pix_hs = hs;
        i_pix_vs = vs;
        i_pix_d  = 10'(d);
        @(negedge clk);
    endtask

    task automatic frame_start();
        cyc(0, 1, 0);
        cyc(0, 1, 0);
    endtask

    task automatic send_line(input int n, input int start);
        for (int i = 0; i < n; i++) cyc(1, 1, start + i);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
    endtask

    task automatic frame_end();
        for (int i = 0; i < 8; i++) cyc(0, 0, 0);
    endtask

    task automatic test_reset();
        tests++; if (av.valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b want 0", av.valid); end
        tests++; if (av.data !== 32'h0) begin fails++; $display("[TB] FAIL reset_data: got %h want 0", av.data); end
        tests++; if (o_frame_count !== 16'h0) begin fails++; $display("[TB] FAIL reset_frames: got %h want 0", o_frame_count); end
        tests++; if (o_ovf_flag !== 1'b0) begin fails++; $display("[TB] FAIL reset_ovf: got %b want 0", o_ovf_flag); end
        tests++; if (o_drop_count !== 16'h0) begin fails++; $display("[TB] FAIL reset_drops: got %h want 0", o_drop_count); end
        reset_n = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
    endtask

    task automatic test_line6();
        clear_q();
        frame_start();
        cyc(1, 1, 1);
        cyc(1, 1, 2);
        cyc(1, 1, 3);
        tests++; if (av.valid !== 1'b0) begin fails++; $display("[TB] FAIL latency_early: got valid %b want 0", av.valid); end
        cyc(1, 1, 4);
        tests++; if (av.valid !== 1'b1 || av.data !== 32'h00300801) begin fails++; $display("[TB] FAIL latency_word: got valid %b data %h want 1 00300801", av.valid, av.data); end
        cyc(1, 1, 5);
        cyc(1, 1, 6);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        frame_end();
        tests++; if (q_data.size() !== 2) begin fails++; $display("[TB] FAIL line6_count: got %0d want 2", q_data.size()); end
        tests++; if (q_data[0] !== 32'h00300801 || q_sof[0] !== 1'b1 || q_eol[0] !== 1'b0) begin fails++; $display("[TB] FAIL line6_word0: got %h sof %b eol %b want 00300801 1 0", q_data[0], q_sof[0], q_eol[0]); end
        tests++; if (q_data[1] !== 32'h00601404 || q_sof[1] !== 1'b0 || q_eol[1] !== 1'b1) begin fails++; $display("[TB] FAIL line6_word1: got %h sof %b eol %b want 00601404 0 1", q_data[1], q_sof[1], q_eol[1]); end
        tests++; if (o_frame_count !== 16'd1) begin fails++; $display("[TB] FAIL line6_frames: got %0d want 1", o_frame_count); end
    endtask

    task automatic test_line4_partial();
        clear_q();
        frame_start();
        send_line(4, 1);
        frame_end();
        tests++; if (q_data.size() !== 2) begin fails++; $display("[TB] FAIL line4_count: got %0d want 2", q_data.size()); end
        tests++; if (q_data[0] !== 32'h00300801 || q_sof[0] !== 1'b1 || q_eol[0] !== 1'b0) begin fails++; $display("[TB] FAIL line4_word0: got %h sof %b eol %b want 00300801 1 0", q_data[0], q_sof[0], q_eol[0]); end
        tests++; if (q_data[1] !== 32'h00000004 || q_sof[1] !== 1'b0 || q_eol[1] !== 1'b1) begin fails++; $display("[TB] FAIL line4_word1: got %h sof %b eol %b want 00000004 0 1", q_data[1], q_sof[1], q_eol[1]); end
    endtask

    task automatic test_overflow();
        clear_q();
        av.ready = 1'b0;
        frame_start();
        send_line(60, 1);
        frame_end();
        tests++; if (av.valid !== 1'b1 || av.data !== 32'h00300801 || av.sof !== 1'b1) begin fails++; $display("[TB] FAIL ovf_head_held: got valid %b data %h sof %b want 1 00300801 1", av.valid, av.data, av.sof); end
        tests++; if (o_ovf_flag !== 1'b1) begin fails++; $display("[TB] FAIL ovf_flag: got %b want 1", o_ovf_flag); end
        tests++; if (o_drop_count !== 16'd4) begin fails++; $display("[TB] FAIL ovf_drops: got %0d want 4", o_drop_count); end
        i_ovf_clr = 1'b1;
        cyc(0, 0, 0);
        i_ovf_clr = 1'b0;
        tests++; if (o_ovf_flag !== 1'b0 || o_drop_count !== 16'd0) begin fails++; $display("[TB] FAIL ovf_clear: got flag %b drops %0d want 0 0", o_ovf_flag, o_drop_count); end
        av.ready = 1'b1;
        for (int i = 0; i < 24; i++) cyc(0, 0, 0);
        tests++; if (q_data.size() !== 16) begin fails++; $display("[TB] FAIL ovf_held: got %0d want 16", q_data.size()); end
        tests++; if (q_data[15] !== 32'h0300BC2E || q_eol[15] !== 1'b0) begin fails++; $display("[TB] FAIL ovf_last_held: got %h eol %b want 0300BC2E 0", q_data[15], q_eol[15]); end
    endtask

    task automatic test_reset_midline();
        clear_q();
        frame_start();
        for (int k = 1; k <= 4; k++) cyc(1, 1, k);
        reset_n = 1'b0;
        cyc(1, 1, 5);
        tests++; if (av.valid !== 1'b0 || av.data !== 32'h0 || av.sof !== 1'b0 || av.eol !== 1'b0) begin fails++; $display("[TB] FAIL rst_stream: got valid %b data %h sof %b eol %b want all 0", av.valid, av.data, av.sof, av.eol); end
        tests++; if (o_frame_count !== 16'd0 || o_ovf_flag !== 1'b0 || o_drop_count !== 16'd0) begin fails++; $display("[TB] FAIL rst_status: got frames %0d ovf %b drops %0d want 0 0 0", o_frame_count, o_ovf_flag, o_drop_count); end
        reset_n = 1'b1;
        clear_q();
        for (int k = 6; k <= 9; k++) cyc(1, 1, k);
        cyc(0, 1, 0);
        send_line(6, 1);
        frame_end();
        tests++; if (q_data.size() !== 0) begin fails++; $display("[TB] FAIL rst_ignored_frame: got %0d words want 0", q_data.size()); end
        tests++; if (o_frame_count !== 16'd1) begin fails++; $display("[TB] FAIL rst_frames: got %0d want 1", o_frame_count); end
        frame_start();
        send_line(3, 1);
        frame_end();
        tests++; if (q_data.size() !== 1 || q_data[0] !== 32'h00300801 || q_sof[0] !== 1'b1 || q_eol[0] !== 1'b1) begin fails++; $display("[TB] FAIL rst_next_frame: got n %0d data %h sof %b eol %b want 1 00300801 1 1", q_data.size(), q_data[0], q_sof[0], q_eol[0]); end
    endtask

    task automatic test_capture_off();
        clear_q();
        i_capture_en = 1'b0;
        frame_start();
        i_capture_en = 1'b1;
        send_line(3, 1);
        send_line(3, 4);
        frame_end();
        tests++; if (q_data.size() !== 0) begin fails++; $display("[TB] FAIL capoff_words: got %0d want 0", q_data.size()); end
        tests++; if (o_frame_count !== 16'd3) begin fails++; $display("[TB] FAIL capoff_frames: got %0d want 3", o_frame_count); end
    endtask

`ifdef MIPI_PACK_CROP_EN
    task automatic test_crop();
        clear_q();
        i_crop_x = 16'd2;
        i_crop_w = 16'd3;
        i_crop_y = 16'd1;
        i_crop_h = 16'd1;
        frame_start();
        for (int y = 0; y < 3; y++) send_line(8, 10 * y);
        frame_end();
        tests++; if (q_data.size() !== 1 || q_data[0] !== 32'h00E0340C || q_sof[0] !== 1'b1 || q_eol[0] !== 1'b1) begin fails++; $display("[TB] FAIL crop_word: got n %0d data %h sof %b eol %b want 1 00E0340C 1 1", q_data.size(), q_data[0], q_sof[0], q_eol[0]); end
    endtask
`endif

    initial begin
        reset_n      = 1'b0;
        i_pix_d      = '0;
        i_pix_hs     = 1'b0;
        i_pix_vs     = 1'b0;
        i_capture_en = 1'b1;
        i_ovf_clr    = 1'b0;
        av.ready     = 1'b1;
`ifdef MIPI_PACK_CROP_EN
        i_crop_x = '0;
        i_crop_y = '0;
        i_crop_w = '0;
        i_crop_h = '0;
`endif
        repeat (3) @(negedge clk);
        test_reset();
        test_line6();
        test_line4_partial();
        test_overflow();
        test_reset_midline();
        test_capture_off();
`ifdef MIPI_PACK_CROP_EN
        test_crop();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
